disp_i2c_seq: RTL
=================

// Module: disp_i2c_seq
// PURPOSE
//  Transaction sequencer between the Wishbone display register file and the byte-level I2C PHY driving scl/sda.
//  Turns one "transfer" request (command or data, N bytes) into START, addr+W, control byte, N payload bytes, STOP.
//  Checks the ACK after every byte. Aborts cleanly on NACK.
//  Reports done/error status back to the register file.
// PARAMETERS
//  DEV_ADDR   7'h3C  7-bit I2C slave address of the display
//  TO_CYCLES  4096   watchdog limit in clk cycles per PHY op (used only with DISP_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  req_valid    in   1  transfer request
//  req_ready    out  1  sequencer idle, request accepted on valid&ready
//  req_is_data  in   1  0: control byte 8'h00 (command); 1: control byte 8'h40 (GDDRAM data)
//  req_len      in   8  payload bytes minus 1 (0 => 1 byte, 255 => 256 bytes)
//  byte_valid   in   1  payload byte available
//  byte_ready   out  1  payload byte consumed on valid&ready
//  byte_data    in   8  payload byte
//  phy_valid    out  1  PHY op request, held until phy_ready
//  phy_ready    in   1  PHY accepted op
//  phy_op       out  2  00 START, 01 WRITE, 10 STOP
//  phy_wdata    out  8  byte for WRITE
//  phy_done     in   1  1-cycle pulse: op finished on the bus
//  phy_nack     in   1  valid with phy_done on WRITE: slave NACKed
//  busy         out  1  transfer in progress
//  done_p       out  1  1-cycle pulse when STOP completes
//  err_nack     out  1  sticky, set on NACK, cleared on next accepted request
//  err_to       out  1  sticky timeout flag (0 when macro off), same clear rule
// BEHAVIOUR
//  Reset: state IDLE. req_ready=1. busy, phy_valid, byte_ready, done_p, err_nack and err_to are 0. phy_op=STOP, phy_wdata=0. Counters are 0.
//  FSM: IDLE -> START -> ADDR -> CTRL -> LOAD -> DATA -> STOP -> IDLE.
//   IDLE: on req_valid&req_ready, latch is_data and len. Clear err flags. busy=1 next cycle.
//   Each op state (START, ADDR, CTRL, DATA, STOP) has two phases:
//    - Issue phase: assert phy_valid with op/wdata stable until phy_ready. Drop phy_valid the cycle after the handshake.
//    - Wait phase: wait for phy_done. A phy_done outside the wait phase is ignored.
//   ADDR: wdata={DEV_ADDR,1'b0}. CTRL: wdata=is_data?8'h40:8'h00.
//   LOAD: byte_ready=1 until byte_valid; the byte is captured into phy_wdata in the same cycle. No timeout while starving.
//   DATA: WRITE the byte. On done: if cnt==len go to STOP, else cnt++ and go to LOAD.
//   Any WRITE done with phy_nack=1: set err_nack and go to STOP. Remaining payload is NOT consumed (the register file flushes).
//   STOP done: done_p=1 for one cycle, busy=0, return to IDLE. req_ready=1 the same cycle.
//  Latency: the request handshake is followed by phy_valid for START on the next cycle. done_p is asserted 1 cycle after STOP's phy_done.
//  Counter: 8-bit. cnt==len comparison, so len=255 sends 256 bytes with no wrap ambiguity.
//  req_valid while busy: ignored (req_ready=0). phy_done and phy_ready in the same cycle are legal. The op completes in one cycle. The next op issues in the following cycle.
//  Reset mid-transfer: immediate return to IDLE, no STOP issued. The PHY is reset by the same reset.
// CONFIGURATION
//  DISP_SEQ_TIMEOUT_EN defined:
//   - A 16-bit watchdog counts cycles in each issue or wait phase, except LOAD.
//   - At TO_CYCLES: set err_to, drop phy_valid, go to IDLE without STOP. Pulse done_p.
//  Not defined: no watchdog logic. err_to is tied to 0. The FSM waits forever.
// STRUCTURE
//  disp_seq_pkg:
//   - state encoding
//   - PHY_START/PHY_WRITE/PHY_STOP codes
//   - CTRL_CMD=8'h00, CTRL_DATA=8'h40
//  Single module. No sub-module needed. The watchdog is an inline ifdef block.
// TESTING
//  1. req len=0 is_data=0, byte 8'hAF, PHY always ACKs -> ops START, WR 78, WR 00, WR AF, STOP. Then done_p=1 and err=0.
//  2. len=3 is_data=1, bytes 01..04 -> WR 40 then 01,02,03,04. Exactly 4 byte handshakes.
//  3. NACK on the addr byte -> err_nack=1, STOP issued, zero byte_ready pulses, done_p=1.
//  4. byte_valid held low for 50 cycles mid-burst -> phy_valid stays 0 in LOAD. Resumes with no dup/lost bytes. No err_to.
//  5. reset during DATA of len=255 -> next cycle IDLE, req_ready=1, phy_valid=0, cnt=0.
//  6. (TIMEOUT_EN, TO_CYCLES=16) phy_done withheld after START -> err_to=1 at cycle 16, IDLE. The next request clears err_to.

Source files
------------

// File: rtl/disp_seq_pkg.sv
// Shared encodings for the display I2C transaction sequencer:
// FSM states, byte-PHY op codes and SSD-style control bytes.
package disp_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ADDR  = 3'd2,
        S_CTRL  = 3'd3,
        S_LOAD  = 3'd4,
        S_DATA  = 3'd5,
        S_STOP  = 3'd6
    } seq_state_t;

    localparam logic [1:0] PHY_START = 2'b00;
    localparam logic [1:0] PHY_WRITE = 2'b01;
    localparam logic [1:0] PHY_STOP  = 2'b10;

    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;

    function automatic logic [7:0] ctrl_byte(input logic is_data);
        return is_data ? CTRL_DATA : CTRL_CMD;
    endfunction

endpackage

// File: rtl/disp_i2c_seq.sv
// Display I2C transaction sequencer: START, addr+W, control byte, N payload bytes, STOP.
// Optional per-op watchdog enabled by defining DISP_SEQ_TIMEOUT_EN.
module disp_i2c_seq
    import disp_seq_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h3C,
    parameter int         TO_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_is_data,
    input  logic [7:0] req_len,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic [7:0] byte_data,
    output logic       phy_valid,
    input  logic       phy_ready,
    output logic [1:0] phy_op,
    output logic [7:0] phy_wdata,
    input  logic       phy_done,
    input  logic       phy_nack,
    output logic       busy,
    output logic       done_p,
    output logic       err_nack,
    output logic       err_to
);

    seq_state_t state;
    logic       wait_ph;
    logic       is_data;
    logic [7:0] len;
    logic [7:0] cnt;
    logic       op_done;
    logic       is_write_state;

    // A done pulse counts in the wait phase, or together with the accepting handshake.
    assign op_done = wait_ph ? phy_done : (phy_valid & phy_ready & phy_done);
    assign is_write_state = (state == S_ADDR) || (state == S_CTRL) || (state == S_DATA);

`ifdef DISP_SEQ_TIMEOUT_EN
    logic [15:0] wd;
    logic        to_flag;
    assign err_to = to_flag;
`else
    logic [15:0] unused_to;
    assign unused_to = 16'(TO_CYCLES);
    assign err_to    = 1'b0;
`endif

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_ph    <= 1'b0;
            is_data    <= 1'b0;
            len        <= 8'd0;
            cnt        <= 8'd0;
            req_ready  <= 1'b1;
            byte_ready <= 1'b0;
            phy_valid  <= 1'b0;
            phy_op     <= PHY_STOP;
            phy_wdata  <= 8'd0;
            busy       <= 1'b0;
            done_p     <= 1'b0;
            err_nack   <= 1'b0;
`ifdef DISP_SEQ_TIMEOUT_EN
            wd         <= 16'd0;
            to_flag    <= 1'b0;
`endif
        end else begin
            done_p <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        is_data   <= req_is_data;
                        len       <= req_len;
                        cnt       <= 8'd0;
                        err_nack  <= 1'b0;
`ifdef DISP_SEQ_TIMEOUT_EN
                        to_flag   <= 1'b0;
`endif
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        phy_valid <= 1'b1;
                        phy_op    <= PHY_START;
                        phy_wdata <= 8'd0;
                        wait_ph   <= 1'b0;
                        state     <= S_START;
                    end
                end
                S_LOAD: begin
                    // Starving here is legitimate back-pressure from the register file.
                    if (byte_valid && byte_ready) begin
                        phy_wdata  <= byte_data;
                        byte_ready <= 1'b0;
                        phy_valid  <= 1'b1;
                        phy_op     <= PHY_WRITE;
                        wait_ph    <= 1'b0;
                        state      <= S_DATA;
                    end
                end
                S_START, S_ADDR, S_CTRL, S_DATA, S_STOP: begin
                    if (op_done) begin
                        wait_ph   <= 1'b0;
                        phy_valid <= 1'b0;
                        if ((is_write_state && phy_nack) ||
                            (state == S_DATA && cnt == len)) begin
                            if (phy_nack) begin
                                err_nack <= 1'b1;
                            end
                            phy_valid <= 1'b1;
                            phy_op    <= PHY_STOP;
                            phy_wdata <= 8'd0;
                            state     <= S_STOP;
                        end else if (state == S_START) begin
                            phy_valid <= 1'b1;
                            phy_op    <= PHY_WRITE;
                            phy_wdata <= {DEV_ADDR, 1'b0};
                            state     <= S_ADDR;
                        end else if (state == S_ADDR) begin
                            phy_valid <= 1'b1;
                            phy_op    <= PHY_WRITE;
                            phy_wdata <= ctrl_byte(is_data);
                            state     <= S_CTRL;
                        end else if (state == S_STOP) begin
                            done_p    <= 1'b1;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            if (state == S_DATA) begin
                                cnt <= cnt + 8'd1;
                            end
                            byte_ready <= 1'b1;
                            state      <= S_LOAD;
                        end
                    end else if (!wait_ph && phy_valid && phy_ready) begin
                        phy_valid <= 1'b0;
                        wait_ph   <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
`ifdef DISP_SEQ_TIMEOUT_EN
            // Watchdog restarts on every handshake or completion; LOAD and IDLE never time out.
            if (state != S_IDLE && state != S_LOAD) begin
                if (op_done || (!wait_ph && phy_valid && phy_ready)) begin
                    wd <= 16'd0;
                end else if (wd == 16'(TO_CYCLES - 1)) begin
                    wd         <= 16'd0;
                    to_flag    <= 1'b1;
                    phy_valid  <= 1'b0;
                    byte_ready <= 1'b0;
                    wait_ph    <= 1'b0;
                    busy       <= 1'b0;
                    req_ready  <= 1'b1;
                    done_p     <= 1'b1;
                    state      <= S_IDLE;
                end else begin
                    wd <= wd + 16'd1;
                end
            end else begin
                wd <= 16'd0;
            end
`endif
        end
    end

endmodule
